// File: rtl/vga_sync_gen.sv
// VGA raster timing: a pixel-rate strobe from a clock divider, horizontal/vertical
// pixel counters, registered active-low syncs and a frame-wrap pulse.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_MAX  = 4'(TICK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       p_tick_q, p_tick_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;

  always_comb begin
    div_d        = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
    p_tick_d     = (div_q == DIV_MAX);
    x_d          = x_q;
    y_d          = y_q;
    frame_tick_d = 1'b0;

    if (p_tick_q) begin
      if (x_q == H_MAX) begin
        x_d          = 10'd0;
        y_d          = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
        frame_tick_d = (y_q == V_MAX);
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Syncs decode the next counts so they flip on the same edge as the counters.
    hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
    vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= 4'd0;
      p_tick_q     <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      p_tick_q     <= p_tick_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign p_tick     = p_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates VGA 640x480@60 Hz timing for the pong display path. Divides the system clock down to a pixel-rate strobe and maintains horizontal and vertical pixel counters. Drives hsync/vsync to the connector, and drives video_on, pixel_x and pixel_y into the downstream pixel generator. One instance sits between the clock source and the pixel generator.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
TICK_DIV, 2, clk cycles per pixel; legal values 1..16

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
p_tick  output  1  one-clk pixel strobe, every TICK_DIV clks
hsync  output  1  horizontal sync, active-low, registered
vsync  output  1  vertical sync, active-low, registered
video_on  output  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
pixel_y  output  10  current vertical count, 0..V_TOTAL-1
frame_tick  output  1  one-clk pulse on the p_tick where counters wrap to (0,0)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Derived constants:
  - H_TOTAL = sum of H_* = 800.
  - V_TOTAL = sum of V_* = 525.
  - Horizontal sync window: [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
  - Vertical sync window: [490,491].
- Reset (async assert, takes effect immediately):
  - div counter=0, pixel_x=0, pixel_y=0.
  - hsync=1, vsync=1, p_tick=0, frame_tick=0.
  - video_on=1, because it is a combinational decode of the counter registers.
- Divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - p_tick is registered; it is high for exactly one clk when the counter equals TICK_DIV-1.
  - With TICK_DIV=1, p_tick is constantly high from the first clk after reset release.
- Horizontal counter: on each clk with p_tick=1, pixel_x <= (pixel_x==H_TOTAL-1) ? 0 : pixel_x+1.
- Vertical counter: advances only on the p_tick where pixel_x wraps; pixel_y <= (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1.
- Counters and sync are held unchanged when p_tick=0.
- hsync/vsync:
  - Registered and computed from the next-count values.
  - They change in the same clk edge as pixel_x/pixel_y, so hsync==0 exactly while pixel_x is in [656,751].
  - vsync==0 exactly while pixel_y is in [490,491].
  - No added pipeline latency relative to the counters.
- video_on: pure combinational decode of the registered counters; zero latency versus pixel_x/pixel_y.
- frame_tick: registered; high for one clk on the same edge where pixel_x and pixel_y both load 0 from (799,524).
- Widths: all count arithmetic is 10-bit unsigned. Counts never exceed H_TOTAL-1 or V_TOTAL-1, so no overflow is possible.
- Per-line and per-frame counts:
  - A line is exactly H_TOTAL p_ticks; a frame is exactly 420000 p_ticks.
  - A frame is 840000 clks at TICK_DIV=2.
- Reset mid-frame: all state returns to reset values immediately, with no partial-pulse completion. After release, timing restarts from (0,0) with the divider at 0.
- Downstream constraint: the pixel generator's refresh point (pixel_y==481, pixel_x==0) must occur once per frame. This is guaranteed because pixel_y spans 0..524.

Test Plan:
- Reset release, TICK_DIV=2:
  - First p_tick is on the 2nd clk after release; p_ticks then repeat every 2 clks.
  - pixel_x is 1 after the first p_tick; hsync=1, vsync=1, video_on=1.
- Horizontal timing, TICK_DIV=1:
  - hsync falls on the edge where pixel_x becomes 656 and rises where pixel_x becomes 752.
  - video_on goes low when pixel_x becomes 640 and high again at pixel_x=0.
- Line wrap: pixel_x=799 at pixel_y=10 -> next p_tick gives pixel_x=0, pixel_y=11, frame_tick=0.
- Frame wrap: (799,524) -> next p_tick gives (0,0) with frame_tick=1 for exactly one clk. Measured interval between frame_ticks is 420000 p_ticks.
- Vertical timing:
  - vsync=0 only for pixel_y 490 and 491, i.e. 1600 p_ticks.
  - video_on=0 for all pixel_y in 480..524 regardless of pixel_x.
- Mid-frame reset at (300,200) with hsync=1:
  - Outputs immediately become pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0.
  - After release, the sequence matches the first scenario exactly.
